// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: sequencer states, vectors,
// PC increment and a target alignment helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } pc_state_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;
    localparam logic [31:0] PC_INC        = 32'd4;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: exception, misaligned target, branch,
// jump, stall, then sequential increment.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc_i,
    input  logic        exc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        stall_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o,
    output logic        exc_o
);

    logic [31:0] tgt;
    logic        tgt_sel;

    // A taken branch shadows a same-cycle jump.
    assign tgt     = br_taken_i ? br_target_i : jump_target_i;
    assign tgt_sel = br_taken_i | jump_i;

    always_comb begin
        next_pc_o  = pc_i + PC_INC;
        redirect_o = 1'b0;
        exc_o      = 1'b0;
        if (exc_i) begin
            next_pc_o = EXC_VEC;
            exc_o     = 1'b1;
        end else if (tgt_sel && misaligned(tgt)) begin
            next_pc_o = EXC_VEC;
            exc_o     = 1'b1;
        end else if (tgt_sel) begin
            next_pc_o  = tgt;
            redirect_o = 1'b1;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, run, one-cycle redirect flush and halt,
// with exception PC capture.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        exc_i,
    input  logic        halt_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic [31:0] epc_o,
    output logic [1:0]  state_o
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        flush_q;

    logic [31:0] sel_pc;
    logic        sel_redir;
    logic        sel_exc;
    logic [31:0] bad_tgt;

    pc_next_sel #(
        .EXC_VEC (EXC_VEC)
    ) u_sel (
        .pc_i          (pc_q),
        .exc_i         (exc_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .stall_i       (stall_i),
        .next_pc_o     (sel_pc),
        .redirect_o    (sel_redir),
        .exc_o         (sel_exc)
    );

    assign bad_tgt = br_taken_i ? br_target_i : jump_target_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_REDIRECT: begin
                pc_d = sel_pc;
                if (sel_exc) begin
                    state_d = ST_REDIRECT;
                    epc_d   = exc_i ? pc_q : bad_tgt;
                end else if (sel_redir) begin
                    state_d = ST_REDIRECT;
                end else if (state_q == ST_RUN && halt_i) begin
                    state_d = ST_HALT;
                    pc_d    = pc_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (exc_i) begin
                    state_d = ST_REDIRECT;
                    pc_d    = EXC_VEC;
                    epc_d   = pc_q;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            flush_q <= (state_d == ST_REDIRECT);
        end
    end

    assign pc_o       = pc_q;
    assign epc_o      = epc_q;
    assign flush_o    = flush_q;
    assign state_o    = state_q;
    assign pc_valid_o = (state_q == ST_RUN) || (state_q == ST_REDIRECT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic
// checked against a behavioural PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, br_taken_i, jump_i, exc_i, halt_i;
    logic [31:0] br_target_i, jump_target_i;
    logic [31:0] pc_o, epc_o;
    logic        pc_valid_o, flush_o;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // model: 0 boot, 1 run, 2 redirect, 3 halt
    int          m_st;
    logic [31:0] m_pc, m_epc;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .exc_i         (exc_i),
        .halt_i        (halt_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .flush_o       (flush_o),
        .epc_o         (epc_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc_o, m_pc);
        chk({tag, ".epc"}, epc_o, m_epc);
        chk({tag, ".st"}, 32'(state_o), 32'(m_st));
        chk({tag, ".vld"}, 32'(pc_valid_o), 32'(m_st == 1 || m_st == 2));
        chk({tag, ".fl"}, 32'(flush_o), 32'(m_st == 2));
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pc  = 32'h0;
        m_epc = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        bit          has_t;
        has_t = br_taken_i || jump_i;
        t     = br_taken_i ? br_target_i : jump_target_i;
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 3) begin
            if (exc_i) begin
                m_epc = m_pc;
                m_pc  = 32'h180;
                m_st  = 2;
            end
        end else if (exc_i) begin
            m_epc = m_pc;
            m_pc  = 32'h180;
            m_st  = 2;
        end else if (has_t && (t % 4 != 0)) begin
            m_epc = t;
            m_pc  = 32'h180;
            m_st  = 2;
        end else if (has_t) begin
            m_pc = t;
            m_st = 2;
        end else if (m_st == 1 && halt_i) begin
            m_st = 3;
        end else begin
            if (!stall_i) m_pc = m_pc + 4;
            m_st = 1;
        end
    endtask

    task automatic drive(input bit b, input logic [31:0] bt, input bit j,
                         input logic [31:0] jt, input bit e, input bit s,
                         input bit h);
        br_taken_i    = b;
        br_target_i   = bt;
        jump_i        = j;
        jump_target_i = jt;
        exc_i         = e;
        stall_i       = s;
        halt_i        = h;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic jmp(input logic [31:0] t, input string tag);
        drive(0, 32'h0, 1, t, 0, 0, 0);
        cyc(tag);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("boot");
        chk("boot.vld0", 32'(pc_valid_o), 32'h0);

        for (int i = 0; i < 4; i++) cyc("seq");
        chk("seq.pcC", pc_o, 32'hC);
        cyc("seq10");

        drive(1, 32'h40, 1, 32'h80, 0, 0, 0);
        cyc("brj");
        chk("brj.pc40", pc_o, 32'h40);
        chk("brj.fl1", 32'(flush_o), 32'h1);
        idle();
        cyc("brj2");
        chk("brj.pc44", pc_o, 32'h44);

        jmp(32'h20, "j20");
        drive(0, 32'h0, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("stall");
        chk("stall.pc20", pc_o, 32'h20);
        drive(0, 32'h0, 1, 32'h100, 0, 1, 0);
        cyc("stj");
        chk("stj.pc100", pc_o, 32'h100);

        jmp(32'h30, "j30");
        jmp(32'h102, "mis");
        chk("mis.pc", pc_o, 32'h180);
        chk("mis.epc", epc_o, 32'h102);

        jmp(32'h4C, "j4c");
        idle();
        cyc("run50");
        drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
        cyc("halt");
        chk("halt.st", 32'(state_o), 32'h3);
        drive(1, 32'h200, 0, 32'h0, 0, 0, 0);
        cyc("hbr");
        chk("hbr.pc50", pc_o, 32'h50);
        drive(0, 32'h0, 0, 32'h0, 1, 0, 0);
        cyc("hexc");
        chk("hexc.epc", epc_o, 32'h50);

        jmp(32'hFFFF_FFF8, "jwrap");
        idle();
        cyc("wrap1");
        cyc("wrap2");
        chk("wrap.pc0", pc_o, 32'h0);

        jmp(32'h200, "j200");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        chk("midrst.pc", pc_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("boot2");

        for (int i = 0; i < 600; i++) begin
            logic [31:0] bt, jt;
            bit          h;
            bt = $urandom & ~32'h3;
            jt = $urandom & ~32'h3;
            if ($urandom_range(0, 5) == 0) bt = bt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) jt = jt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) jt = 32'hFFFF_FFF4;
            h = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 7) == 0, bt,
                  $urandom_range(0, 7) == 0, jt,
                  $urandom_range(0, 19) == 0,
                  !h && ($urandom_range(0, 3) == 0), h);
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
